// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
//   Sweeps every input vector of an N_IN-input, 1-output combinational
//   function, holds each vector for HOLD cycles, samples the function output
//   into a truth-table register, and compares the finished table against a
//   golden table.
//
// Parameters
//   N_IN  number of function inputs (1..6); table width is 2**N_IN
//   HOLD  cycles each vector is held before sampling (>= 1)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      single-cycle sweep request (ignored while sweeping)
//   y_i          output of the function under control
//   expected_i   golden table, bit k = expected Y for vector k
//   vec_o        vector driven to the function (MSB = first input)
//   busy_o       sweep in progress
//   done_o       sweep finished, held until the next accepted start
//   table_o      captured table, bit k = y_i sampled for vector k
//   match_o      done_o && (table_o == expected_i)
//
// Optional feature (macro TT_SWEEP_FIRST_FAIL_EN)
//   first_fail_o  first vector whose sample differed from expected_i
//   fail_seen_o   set once any sampled vector has differed
module tt_sweep_ctrl #(
  parameter int unsigned N_IN = 3,
  parameter int unsigned HOLD = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  y_i,
  input  logic [2**N_IN-1:0]    expected_i,
  output logic [N_IN-1:0]       vec_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2**N_IN-1:0]    table_o,
  output logic                  match_o
`ifdef TT_SWEEP_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]       first_fail_o,
  output logic                  fail_seen_o
`endif
);

  localparam int unsigned TBL_W = 2**N_IN;
  localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [N_IN-1:0]   vec_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TBL_W-1:0]  table_q;

  logic accept;
  logic sample;
  logic last_vec;

  // Start is honoured in IDLE and DONE alike; DRIVE never restarts.
  assign accept   = (state_q != DRIVE) && start_i;
  assign sample   = (state_q == DRIVE) && (cnt_q == CNT_LAST);
  assign last_vec = (vec_q == VEC_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = DRIVE;
      DRIVE:   if (sample && last_vec) state_d = DONE;
      DONE:    if (start_i) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // Vector, hold counter and captured table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
    end else if (accept) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
    end else if (state_q == DRIVE) begin
      if (sample) begin
        table_q[vec_q] <= y_i;
        cnt_q          <= '0;
        // Terminal vector ends the sweep; vec_o parks at 0 in DONE.
        vec_q          <= last_vec ? '0 : vec_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic [N_IN-1:0] first_fail_q;
  logic            fail_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else if (accept) begin
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else if (sample && !fail_seen_q && (y_i != expected_i[vec_q])) begin
      first_fail_q <= vec_q;
      fail_seen_q  <= 1'b1;
    end
  end

  assign first_fail_o = first_fail_q;
  assign fail_seen_o  = fail_seen_q;
`endif

  // Output logic
  always_comb begin
    busy_o  = (state_q == DRIVE);
    done_o  = (state_q == DONE);
    vec_o   = vec_q;
    table_o = table_q;
    match_o = (state_q == DONE) && (table_q == expected_i);
  end

endmodule
